// File: rtl/poly_sound_generator.sv
// Multi-voice square-wave synthesiser with a triangle LFO, an LFSR noise source
// and a first-order sigma-delta modulator that drives a 1-bit audio pin.
module poly_sound_generator #(
    parameter int NUM_VOICES = 4,
    parameter int FREQ_WIDTH = 12,
    parameter int VOL_WIDTH  = 4,
    parameter int LFO_WIDTH  = 12
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cfg_we,
    input  logic [2:0]                      cfg_addr,
    input  logic [FREQ_WIDTH+VOL_WIDTH:0]   cfg_data,
    input  logic [LFO_WIDTH-1:0]            lfo_freq,
    input  logic [2:0]                      lfo_shift,
    input  logic [FREQ_WIDTH-1:0]           noise_freq,
    input  logic [VOL_WIDTH-1:0]            noise_vol,
    output logic [NUM_VOICES-1:0]           voice_active,
    output logic                            signal_out
);

    localparam int SUM_W = VOL_WIDTH + $clog2(NUM_VOICES + 1);
    localparam int EXT_W = ((FREQ_WIDTH > 8) ? FREQ_WIDTH : 8) + 1;
    localparam logic [EXT_W-1:0] PMAX = EXT_W'({FREQ_WIDTH{1'b1}});
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Modulated reload value, clamped to the largest representable half-period.
    function automatic logic [FREQ_WIDTH-1:0] sat_eff(
        input logic [FREQ_WIDTH-1:0] per,
        input logic                  mod_en,
        input logic [7:0]            tri_v,
        input logic [2:0]            sh
    );
        logic [EXT_W-1:0] s;
        s = EXT_W'(per) + (mod_en ? EXT_W'(tri_v >> sh) : '0);
        if (s > PMAX) return '1;
        return s[FREQ_WIDTH-1:0];
    endfunction

    logic [FREQ_WIDTH-1:0] cfg_period;
    logic [VOL_WIDTH-1:0]  cfg_vol;
    logic                  cfg_mod;

    assign cfg_period = cfg_data[FREQ_WIDTH-1:0];
    assign cfg_vol    = cfg_data[FREQ_WIDTH +: VOL_WIDTH];
    assign cfg_mod    = cfg_data[FREQ_WIDTH+VOL_WIDTH];

    logic [FREQ_WIDTH-1:0] period_q [NUM_VOICES];
    logic [FREQ_WIDTH-1:0] period_d [NUM_VOICES];
    logic [FREQ_WIDTH-1:0] cnt_q    [NUM_VOICES];
    logic [FREQ_WIDTH-1:0] cnt_d    [NUM_VOICES];
    logic [VOL_WIDTH-1:0]  vol_q    [NUM_VOICES];
    logic [VOL_WIDTH-1:0]  vol_d    [NUM_VOICES];
    logic [NUM_VOICES-1:0] mod_q, mod_d, sq_q, sq_d;

    logic [LFO_WIDTH-1:0]  lfo_cnt_q, lfo_cnt_d;
    logic [7:0]            tri_q, tri_d;
    logic                  dir_up_q, dir_up_d;

    logic [FREQ_WIDTH-1:0] noise_cnt_q, noise_cnt_d;
    logic [15:0]           lfsr_q, lfsr_d;

    logic [SUM_W-1:0]      sum_q, sum_d;
    logic [SUM_W-1:0]      acc_q, acc_d;
    logic [SUM_W:0]        sd_total;
    logic                  out_q;

    // A write landing on a reload cycle is seen by that reload; otherwise the
    // running half-period finishes on the old value.
    always_comb begin
        for (int i = 0; i < NUM_VOICES; i++) begin
            period_d[i] = period_q[i];
            vol_d[i]    = vol_q[i];
            mod_d[i]    = mod_q[i];
            cnt_d[i]    = cnt_q[i];
            sq_d[i]     = sq_q[i];
            if (cfg_we && (cfg_addr == 3'(i))) begin
                period_d[i] = cfg_period;
                vol_d[i]    = cfg_vol;
                mod_d[i]    = cfg_mod;
            end
            if (period_d[i] == '0) begin
                cnt_d[i] = '0;
                sq_d[i]  = 1'b0;
            end else if (cnt_q[i] == '0) begin
                cnt_d[i] = sat_eff(period_d[i], mod_q[i], tri_q, lfo_shift);
                sq_d[i]  = ~sq_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] - FREQ_WIDTH'(1);
            end
        end
    end

    always_comb begin
        lfo_cnt_d = lfo_cnt_q;
        tri_d     = tri_q;
        dir_up_d  = dir_up_q;
        if (lfo_freq != '0) begin
            if (lfo_cnt_q == '0) begin
                lfo_cnt_d = lfo_freq;
                if (dir_up_q) begin
                    if (tri_q == 8'hFF) begin
                        tri_d    = 8'hFE;
                        dir_up_d = 1'b0;
                    end else begin
                        tri_d = tri_q + 8'd1;
                    end
                end else begin
                    if (tri_q == 8'h00) begin
                        tri_d    = 8'h01;
                        dir_up_d = 1'b1;
                    end else begin
                        tri_d = tri_q - 8'd1;
                    end
                end
            end else begin
                lfo_cnt_d = lfo_cnt_q - LFO_WIDTH'(1);
            end
        end
    end

    always_comb begin
        noise_cnt_d = noise_cnt_q;
        lfsr_d      = lfsr_q;
        if (noise_freq != '0) begin
            if (noise_cnt_q == '0) begin
                noise_cnt_d = noise_freq;
                lfsr_d      = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
            end else begin
                noise_cnt_d = noise_cnt_q - FREQ_WIDTH'(1);
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (sq_q[i]) sum_d = sum_d + SUM_W'(vol_q[i]);
        end
        if (lfsr_q[0]) sum_d = sum_d + SUM_W'(noise_vol);
    end

    // The accumulator carry is the output bit; its density equals sum_q / 2^SUM_W.
    assign sd_total = {1'b0, acc_q} + {1'b0, sum_q};
    assign acc_d    = sd_total[SUM_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
                vol_q[i]    <= '0;
            end
            mod_q       <= '0;
            sq_q        <= '0;
            lfo_cnt_q   <= '0;
            tri_q       <= '0;
            dir_up_q    <= 1'b1;
            noise_cnt_q <= '0;
            lfsr_q      <= 16'h0001;
            sum_q       <= '0;
            acc_q       <= '0;
            out_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
                vol_q[i]    <= vol_d[i];
            end
            mod_q       <= mod_d;
            sq_q        <= sq_d;
            lfo_cnt_q   <= lfo_cnt_d;
            tri_q       <= tri_d;
            dir_up_q    <= dir_up_d;
            noise_cnt_q <= noise_cnt_d;
            lfsr_q      <= lfsr_d;
            sum_q       <= sum_d;
            acc_q       <= acc_d;
            out_q       <= sd_total[SUM_W];
        end
    end

    always_comb begin
        voice_active = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            voice_active[i] = (period_q[i] != '0);
        end
    end

    assign signal_out = out_q;

endmodule

// File: tb/tb_poly_sound_generator.sv
// Scoreboarded bench for poly_sound_generator: a behavioural model predicts the
// audio bit and voice_active every cycle; directed density checks cover the mixer.
module tb_poly_sound_generator;

    localparam int NV   = 4;
    localparam int FULL = 128;   // 2^(VOL_WIDTH + clog2(NV+1))
    localparam int PMAXV = 4095;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [16:0] cfg_data;
    logic [11:0] lfo_freq;
    logic [2:0]  lfo_shift;
    logic [11:0] noise_freq;
    logic [3:0]  noise_vol;
    logic [3:0]  voice_active;
    logic        signal_out;

    int checks = 0;
    int errors = 0;

    poly_sound_generator #(
        .NUM_VOICES(NV), .FREQ_WIDTH(12), .VOL_WIDTH(4), .LFO_WIDTH(12)
    ) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .lfo_freq(lfo_freq), .lfo_shift(lfo_shift),
        .noise_freq(noise_freq), .noise_vol(noise_vol),
        .voice_active(voice_active), .signal_out(signal_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state: time left in the current half-period, level, etc.
    int m_per[NV], m_vol[NV], m_mod[NV], m_left[NV], m_lvl[NV];
    int m_tri, m_step, m_lfo_left, m_noise_left, m_mix, m_acc, m_out;
    logic [15:0] m_lfsr;
    logic [4:0]  exp_q[$];

    task automatic m_reset();
        for (int v = 0; v < NV; v++) begin
            m_per[v] = 0; m_vol[v] = 0; m_mod[v] = 0; m_left[v] = 0; m_lvl[v] = 0;
        end
        m_tri = 0; m_step = 1; m_lfo_left = 0; m_noise_left = 0;
        m_lfsr = 16'h0001; m_mix = 0; m_acc = 0; m_out = 0;
    endtask

    task automatic m_advance();
        int tot, mix_next, np, eff, act;
        bit hit;
        tot = m_acc + m_mix;
        m_out = (tot >= FULL) ? 1 : 0;
        m_acc = tot % FULL;
        mix_next = m_lfsr[0] ? int'(noise_vol) : 0;
        for (int v = 0; v < NV; v++) mix_next += m_lvl[v] * m_vol[v];
        for (int v = 0; v < NV; v++) begin
            hit = cfg_we && (int'(cfg_addr) == v);
            np = hit ? int'(cfg_data[11:0]) : m_per[v];
            if (np == 0) begin
                m_left[v] = 0; m_lvl[v] = 0;
            end else if (m_left[v] == 0) begin
                eff = np + (m_mod[v] != 0 ? (m_tri >> lfo_shift) : 0);
                if (eff > PMAXV) eff = PMAXV;
                m_left[v] = eff;
                m_lvl[v] = 1 - m_lvl[v];
            end else begin
                m_left[v] -= 1;
            end
            m_per[v] = np;
            if (hit) begin
                m_vol[v] = int'(cfg_data[15:12]);
                m_mod[v] = int'(cfg_data[16]);
            end
        end
        m_mix = mix_next;
        if (lfo_freq != 0) begin
            if (m_lfo_left == 0) begin
                m_lfo_left = int'(lfo_freq);
                if (m_tri + m_step > 255 || m_tri + m_step < 0) m_step = -m_step;
                m_tri += m_step;
            end else m_lfo_left -= 1;
        end
        if (noise_freq != 0) begin
            if (m_noise_left == 0) begin
                m_noise_left = int'(noise_freq);
                m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            end else m_noise_left -= 1;
        end
        act = 0;
        for (int v = 0; v < NV; v++) if (m_per[v] != 0) act |= (1 << v);
        exp_q.push_back({1'(m_out), 4'(act)});
    endtask

    initial begin : model
        m_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_reset();
                exp_q.delete();
            end else begin
                m_advance();
            end
        end
    end

    initial begin : monitor
        logic [4:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                checks++;
                if (signal_out !== 1'b0 || voice_active !== 4'b0000) begin
                    errors++;
                    $display("FAIL reset_state @%0t: got out=%b act=%b, expected out=0 act=0000",
                             $time, signal_out, voice_active);
                end
            end else if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (signal_out !== e[4]) begin
                    errors++;
                    $display("FAIL signal_out @%0t: got %b, expected %b", $time, signal_out, e[4]);
                end
                checks++;
                if (voice_active !== e[3:0]) begin
                    errors++;
                    $display("FAIL voice_active @%0t: got %b, expected %b", $time, voice_active, e[3:0]);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int addr, input int md, input int vol, input int per);
        cfg_we   = 1'b1;
        cfg_addr = 3'(addr);
        cfg_data = {1'(md), 4'(vol), 12'(per)};
        tick(1);
        cfg_we   = 1'b0;
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge clk);
            ones += int'(signal_out);
        end
        tick(1);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic quiet_inputs();
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        lfo_freq = '0; lfo_shift = '0; noise_freq = '0; noise_vol = '0;
    endtask

    initial begin : stimulus
        int ones;
        reset = 1'b0;
        quiet_inputs();
        // Random inputs while reset is held must not leak through.
        repeat (10) begin
            cfg_we = 1'($urandom); cfg_addr = 3'($urandom); cfg_data = 17'($urandom);
            lfo_freq = 12'($urandom); lfo_shift = 3'($urandom);
            noise_freq = 12'($urandom); noise_vol = 4'($urandom);
            tick(1);
        end
        quiet_inputs();
        reset = 1'b1;
        count_ones(1000, ones);
        check_range("idle_ones", ones, 0, 0);
        check_range("idle_active", int'(voice_active), 0, 0);

        // Single tone: period 3 -> square period 8, density 7.5/128.
        wr(0, 0, 15, 3);
        check_range("tone_active", int'(voice_active), 1, 1);
        tick(4);
        count_ones(1024, ones);
        check_range("tone_ones", ones, 59, 61);

        // Deferred period update and silencing on voice 1.
        wr(1, 0, 15, 9);
        check_range("v1_active", int'(voice_active), 3, 3);
        tick(4);
        wr(1, 0, 15, 2);
        tick(30);
        wr(1, 0, 15, 0);
        check_range("v1_silenced", int'(voice_active), 1, 1);
        tick(20);

        // LFO modulation, then saturation at the top of the range.
        wr(0, 1, 15, 100);
        lfo_freq = 12'd1; lfo_shift = 3'd0;
        tick(3000);
        lfo_shift = 3'd7;
        tick(500);
        lfo_shift = 3'd0;
        wr(0, 1, 15, 4000);
        tick(9000);
        wr(0, 1, 15, 4095);
        tick(4500);

        // Noise source from a known LFSR state.
        do_reset();
        quiet_inputs();
        noise_vol = 4'd15;
        tick(50);
        noise_freq = 12'd1;
        tick(400);
        noise_freq = 12'd0;
        tick(100);
        noise_freq = 12'd5;
        tick(300);

        // Out-of-range addresses are ignored.
        do_reset();
        quiet_inputs();
        wr(5, 1, 15, 7);
        wr(4, 0, 15, 3);
        wr(7, 0, 15, 1);
        tick(2);
        check_range("addr_guard", int'(voice_active), 0, 0);
        tick(50);

        // Full scale: every voice high, noise bit high -> 75/128.
        do_reset();
        quiet_inputs();
        noise_vol = 4'd15;
        for (int v = 0; v < NV; v++) wr(v, 0, 15, 4095);
        check_range("full_active", int'(voice_active), 15, 15);
        tick(4);
        count_ones(1280, ones);
        check_range("full_ones", ones, 749, 751);

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) begin
                lfo_freq   = 12'($urandom_range(0, 7));
                lfo_shift  = 3'($urandom_range(0, 7));
                noise_freq = 12'($urandom_range(0, 15));
                noise_vol  = 4'($urandom);
            end
            if ($urandom_range(0, 3) == 0) begin
                cfg_we   = 1'b1;
                cfg_addr = 3'($urandom_range(0, 7));
                cfg_data = {1'($urandom), 4'($urandom),
                            ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 40))};
            end else begin
                cfg_we = 1'b0;
            end
            tick(1);
        end
        cfg_we = 1'b0;
        tick(2);
        check_range("scoreboard_drained", exp_q.size(), 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
